// File: rtl/modulo_captura_entradas.sv
// -----------------------------------------------------------------------------
// modulo_captura_entradas
//
// Input-capture stage for the SECDED (8,4) datapath. Twelve board switches
// (4 data bits plus 8 received-codeword bits) are synchronised with a 2-flop
// synchroniser and debounced as one 12-bit vector. A change reaches the
// outputs only after the synchronised vector has stayed unchanged for
// DEBOUNCE_CYCLES consecutive cycles. Both output words always update
// together, in the same cycle as a one-cycle dato_nuevo strobe.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   sw_entrada    in   [3:0] raw data switches (asynchronous)
//   sw_palabra_rx in   [7:0] raw received-codeword switches (asynchronous)
//   entrada       out  [3:0] debounced data word to the encoder
//   palabra_rx    out  [7:0] debounced received word to the detector
//   dato_nuevo    out  one-cycle pulse when a new snapshot is committed
//   ocupado       out  high while a change is being qualified
// -----------------------------------------------------------------------------
module modulo_captura_entradas #(
  parameter int DEBOUNCE_CYCLES = 270000,
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw_entrada,
  input  logic [7:0] sw_palabra_rx,
  output logic [3:0] entrada,
  output logic [7:0] palabra_rx,
  output logic       dato_nuevo,
  output logic       ocupado
);

  typedef enum logic {
    ESTABLE  = 1'b0,
    CONTANDO = 1'b1
  } estado_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  estado_t          state_q, state_d;
  logic [11:0]      sync1_q, sync1_d;
  logic [11:0]      sync2_q, sync2_d;
  logic [11:0]      cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       entrada_q, entrada_d;
  logic [7:0]       palabra_rx_q, palabra_rx_d;
  logic             dato_nuevo_q, dato_nuevo_d;
  logic             ocupado_q, ocupado_d;
  logic [11:0]      committed;

  assign committed = {palabra_rx_q, entrada_q};

  always_comb begin
    // The first synchroniser flop feeds only the second one; no logic may
    // look at it because it can be metastable.
    sync1_d      = {sw_palabra_rx, sw_entrada};
    sync2_d      = sync1_q;
    state_d      = state_q;
    cand_d       = cand_q;
    cnt_d        = cnt_q;
    entrada_d    = entrada_q;
    palabra_rx_d = palabra_rx_q;
    dato_nuevo_d = 1'b0;

    case (state_q)
      ESTABLE: begin
        if (sync2_q != committed) begin
          cand_d  = sync2_q;
          cnt_d   = '0;
          state_d = CONTANDO;
        end
      end
      CONTANDO: begin
        if (sync2_q == committed) begin
          // Switches bounced back to the committed value: drop the change.
          cnt_d   = '0;
          state_d = ESTABLE;
        end else if (sync2_q != cand_q) begin
          // Still moving: restart qualification on the newest value.
          cand_d = sync2_q;
          cnt_d  = '0;
        end else if (cnt_q == CNT_MAX) begin
          {palabra_rx_d, entrada_d} = cand_q;
          dato_nuevo_d              = 1'b1;
          cnt_d                     = '0;
          state_d                   = ESTABLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ESTABLE;
        cnt_d   = '0;
      end
    endcase

    // Registered copy of the next state so ocupado tracks state_q exactly.
    ocupado_d = (state_d == CONTANDO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ESTABLE;
      sync1_q      <= '0;
      sync2_q      <= '0;
      cand_q       <= '0;
      cnt_q        <= '0;
      entrada_q    <= '0;
      palabra_rx_q <= '0;
      dato_nuevo_q <= 1'b0;
      ocupado_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      entrada_q    <= entrada_d;
      palabra_rx_q <= palabra_rx_d;
      dato_nuevo_q <= dato_nuevo_d;
      ocupado_q    <= ocupado_d;
    end
  end

  assign entrada    = entrada_q;
  assign palabra_rx = palabra_rx_q;
  assign dato_nuevo = dato_nuevo_q;
  assign ocupado    = ocupado_q;

endmodule

// File: tb/tb_modulo_captura_entradas.sv
// -----------------------------------------------------------------------------
// tb_modulo_captura_entradas
//
// Bench for modulo_captura_entradas. Instance u_dut uses DEBOUNCE_CYCLES=4,
// instance u_dut1 uses DEBOUNCE_CYCLES=1. Expected commits are queued when
// the stimulus is driven and compared whenever an instance pulses dato_nuevo;
// cycle-exact checks are made 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_modulo_captura_entradas;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw_entrada;
  logic [7:0] sw_palabra_rx;
  logic [3:0] entrada;
  logic [7:0] palabra_rx;
  logic       dato_nuevo;
  logic       ocupado;

  logic [3:0] sw1_entrada;
  logic [7:0] sw1_palabra_rx;
  logic [3:0] entrada1;
  logic [7:0] palabra_rx1;
  logic       dato_nuevo1;
  logic       ocupado1;

  int checks;
  int failures;

  logic [11:0] sb_q[$];
  logic [11:0] sb1_q[$];

  modulo_captura_entradas #(.DEBOUNCE_CYCLES(4)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw_entrada   (sw_entrada),
    .sw_palabra_rx(sw_palabra_rx),
    .entrada      (entrada),
    .palabra_rx   (palabra_rx),
    .dato_nuevo   (dato_nuevo),
    .ocupado      (ocupado)
  );

  modulo_captura_entradas #(.DEBOUNCE_CYCLES(1)) u_dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw_entrada   (sw1_entrada),
    .sw_palabra_rx(sw1_palabra_rx),
    .entrada      (entrada1),
    .palabra_rx   (palabra_rx1),
    .dato_nuevo   (dato_nuevo1),
    .ocupado      (ocupado1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Step to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboards: every dato_nuevo pulse must match the oldest queued commit.
  always @(negedge clk) begin
    if (rst_n && dato_nuevo) begin
      if (sb_q.size() == 0) check_val("sb_pulso_extra", 32'(1), 32'(0));
      else check_val("sb_commit", 32'({palabra_rx, entrada}), 32'(sb_q.pop_front()));
    end
    if (rst_n && dato_nuevo1) begin
      if (sb1_q.size() == 0) check_val("sb1_pulso_extra", 32'(1), 32'(0));
      else check_val("sb1_commit", 32'({palabra_rx1, entrada1}), 32'(sb1_q.pop_front()));
    end
  end

  initial begin
    checks         = 0;
    failures       = 0;
    rst_n          = 1'b0;
    sw_entrada     = 4'h0;
    sw_palabra_rx  = 8'h00;
    sw1_entrada    = 4'h0;
    sw1_palabra_rx = 8'h00;

    // Reset state, then idle with switches at 0.
    repeat (3) tick();
    check_val("rst_entrada", 32'(entrada), 32'(0));
    check_val("rst_palabra", 32'(palabra_rx), 32'(0));
    check_val("rst_dato", 32'(dato_nuevo), 32'(0));
    check_val("rst_ocupado", 32'(ocupado), 32'(0));
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check_val("idle_out", 32'({palabra_rx, entrada}), 32'(0));
      check_val("idle_dato", 32'(dato_nuevo), 32'(0));
      check_val("idle_ocupado", 32'(ocupado), 32'(0));
    end

    // Clean change 0 -> {5C, A}: ocupado edges 3..6, commit at edge 7.
    sw_entrada    = 4'hA;
    sw_palabra_rx = 8'h5C;
    sb_q.push_back({8'h5C, 4'hA});
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_val("lat_ocupado", 32'(ocupado), 32'((k >= 3 && k <= 6) ? 1 : 0));
      check_val("lat_dato", 32'(dato_nuevo), 32'((k == 7) ? 1 : 0));
      check_val("lat_entrada", 32'(entrada), 32'((k >= 7) ? 4'hA : 4'h0));
      check_val("lat_palabra", 32'(palabra_rx), 32'((k >= 7) ? 8'h5C : 8'h00));
    end

    // Toggle B/A every 2 cycles: never stable long enough to commit.
    for (int i = 0; i < 10; i++) begin
      sw_entrada = (i % 2 == 0) ? 4'hB : 4'hA;
      for (int j = 0; j < 2; j++) begin
        tick();
        check_val("tog_dato", 32'(dato_nuevo), 32'(0));
        check_val("tog_entrada", 32'(entrada), 32'(4'hA));
      end
    end
    sw_entrada = 4'hB;
    sb_q.push_back({8'h5C, 4'hB});
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_val("tog_fin_dato", 32'(dato_nuevo), 32'((k == 7) ? 1 : 0));
      check_val("tog_fin_entrada", 32'(entrada), 32'((k >= 7) ? 4'hB : 4'hA));
    end

    // Two-cycle glitch 5C -> 5D -> 5C: enters CONTANDO, bounces back.
    sw_palabra_rx = 8'h5D;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 2) sw_palabra_rx = 8'h5C;
      check_val("glitch_ocupado", 32'(ocupado), 32'((k == 3 || k == 4) ? 1 : 0));
      check_val("glitch_dato", 32'(dato_nuevo), 32'(0));
      check_val("glitch_out", 32'({palabra_rx, entrada}), 32'({8'h5C, 4'hB}));
    end

    // Change to {00, 3}, reset at edge 5 (mid-count), release at edge 8.
    sw_entrada    = 4'h3;
    sw_palabra_rx = 8'h00;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 5) begin
        rst_n = 1'b0;
        #1;
        check_val("abort_out", 32'({palabra_rx, entrada}), 32'(0));
        check_val("abort_ocupado", 32'(ocupado), 32'(0));
      end
      if (k == 8) begin
        rst_n = 1'b1;
        sb_q.push_back({8'h00, 4'h3});
      end
      if (k < 5) begin
        check_val("pre_abort_ocupado", 32'(ocupado), 32'((k >= 3) ? 1 : 0));
      end else if (k >= 6) begin
        check_val("post_rst_entrada", 32'(entrada), 32'((k >= 15) ? 4'h3 : 4'h0));
        check_val("post_rst_palabra", 32'(palabra_rx), 32'(0));
        check_val("post_rst_dato", 32'(dato_nuevo), 32'((k == 15) ? 1 : 0));
        check_val("post_rst_ocupado", 32'(ocupado), 32'((k >= 11 && k <= 14) ? 1 : 0));
      end
    end

    // DEBOUNCE_CYCLES=1 instance: commit at edge 4.
    sw1_entrada = 4'hF;
    sb1_q.push_back({8'h00, 4'hF});
    for (int k = 1; k <= 6; k++) begin
      tick();
      check_val("n1_ocupado", 32'(ocupado1), 32'((k == 3) ? 1 : 0));
      check_val("n1_dato", 32'(dato_nuevo1), 32'((k == 4) ? 1 : 0));
      check_val("n1_entrada", 32'(entrada1), 32'((k >= 4) ? 4'hF : 4'h0));
    end

    tick();
    check_val("sb_vacia", 32'(sb_q.size()), 32'(0));
    check_val("sb1_vacia", 32'(sb1_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/modulo_captura_entradas.md
Name: modulo_captura_entradas

Overview:
- Input-capture stage directly upstream of the SECDED (8,4) encode/detect/correct datapath.
- Synchronises and debounces the 12 board switches: 4 data bits and 8 received/altered codeword bits.
- Presents a stable, glitch-free registered snapshot to the encoder and detector.
- Emits a one-cycle strobe each time a new stable snapshot is committed.

Parameters:
- DEBOUNCE_CYCLES, 270000, number of consecutive clock cycles the synchronised switch vector must remain unchanged before it is committed (10 ms at 27 MHz). Legal range ≥1. Benches use 4.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width. Derived; not overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sw_entrada  input  4  raw data switches; asynchronous to clk.
- sw_palabra_rx  input  8  raw received-codeword switches; asynchronous to clk.
- entrada  output  4  debounced data word to the encoder.
- palabra_rx  output  8  debounced received word to the detector/corrector.
- dato_nuevo  output  1  one-cycle pulse, high in the cycle the outputs take a new value.
- ocupado  output  1  high while a change is being qualified (state CONTANDO).

Behaviour:
- Reset (rst_n low, asynchronous):
  - Sync flops, candidate, counter, entrada and palabra_rx all cleared to 0.
  - dato_nuevo=0, ocupado=0, state=ESTABLE.
  - Reset asserted mid-count aborts qualification; nothing is committed.
- Concatenated vector v = {sw_palabra_rx, sw_entrada} (12 bits) passes through a 2-flop synchroniser, giving s.
  - No logic on the first flop's output.
  - committed = {palabra_rx, entrada}.
- State ESTABLE:
  - s == committed: stay.
  - s != committed: candidate <= s, cnt <= 0, go CONTANDO.
- State CONTANDO, rules evaluated in priority order each cycle:
  - 1) s == committed (bounce back to old value): cnt <= 0, go ESTABLE, no pulse.
  - 2) s != candidate: candidate <= s, cnt <= 0, stay.
  - 3) cnt == DEBOUNCE_CYCLES-1: committed <= candidate, dato_nuevo <= 1, cnt <= 0, go ESTABLE.
  - 4) Otherwise cnt <= cnt+1.
- dato_nuevo:
  - Registered, asserted exactly one cycle, coincident with the output update. Otherwise 0.
  - Never asserted twice without an intervening committed change.
- ocupado: registered, equals (state == CONTANDO).
- Latency, for a clean switch change sampled at edge 0:
  - s updates at edge 2.
  - CONTANDO with cnt=0 from edge 3.
  - Outputs and dato_nuevo update at edge 3+DEBOUNCE_CYCLES.
- DEBOUNCE_CYCLES=1: commit on the first CONTANDO cycle, i.e. edge 4.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around possible.
- entrada and palabra_rx change only on a commit and always update together; partial updates are forbidden.
- Switches non-zero at reset release: treated as a normal change from 0; commit occurs at edge 3+DEBOUNCE_CYCLES after release, with pulse.
- Purely synchronous after reset; no combinational path from any input to any output.

Test Plan:
- Reset, switches held 0 → all outputs 0 indefinitely, dato_nuevo never pulses, ocupado stays 0.
- N=4, sw_entrada 0→4'hA, sw_palabra_rx 0→8'h5C at edge 0, held → entrada=A, palabra_rx=5C at edge 7; dato_nuevo high only in that cycle; ocupado high for edges 3–6.
- N=4, sw_entrada toggles A/B every 2 cycles for 20 cycles, then holds B → no commit during toggling; single commit entrada=B at edge 7 after final change; one pulse.
- N=4, committed 8'h5C; sw_palabra_rx glitches to 8'h5D for 2 cycles then returns → CONTANDO entered, then bounce back to ESTABLE; outputs stay 5C, no pulse.
- N=4, change to entrada=3 then rst_n low at edge 5 (mid-count), released at edge 8 with switches still 3 → outputs 0 through edge 8+6; commit entrada=3 with pulse at edge 8+7.
- N=1, single change of sw_entrada to 4'hF → commit at edge 4, dato_nuevo one cycle.
